// File: rtl/rgb_pwm_sequencer_if.sv
// Control/status bundle between control logic (master) and rgb_pwm_sequencer (slave).
interface rgb_pwm_sequencer_if #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_BITS = 8
) ();

  localparam int unsigned STEP_W = $clog2(NUM_CH + 1);

  logic                         en;
  logic [1:0]                   mode;
  logic [NUM_CH*PWM_BITS-1:0]   duty_in;
  logic                         load;
  logic [NUM_CH-1:0]            pwm_out;
  logic [STEP_W-1:0]            step_idx;
  logic [PWM_BITS-1:0]          level;

  modport master (
    output en, mode, duty_in, load,
    input  pwm_out, step_idx, level
  );

  modport slave (
    input  en, mode, duty_in, load,
    output pwm_out, step_idx, level
  );

endinterface

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel LED PWM with STATIC / ROTATE / BREATHE modes and period-aligned duty update.
// Optional squaring brightness curve (one extra pipeline stage) when RGB_PWM_GAMMA_EN is defined.
module rgb_pwm_sequencer #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 12000000
) (
  input  logic               int_osc,
  input  logic               rstn,
  rgb_pwm_sequencer_if.slave bus
);

  localparam int unsigned STEP_W = $clog2(NUM_CH + 1);
  localparam int unsigned PRE_W  = $clog2(STEP_CYCLES);
  localparam int unsigned PROD_W = 2 * PWM_BITS;

  localparam logic [1:0] MODE_STATIC  = 2'd0;
  localparam logic [1:0] MODE_ROTATE  = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0]   SLOT_OFF = STEP_W'(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("rgb_pwm_sequencer: NUM_CH must be in 1..8");
  end
  if (STEP_CYCLES < 2) begin : g_bad_step
    $error("rgb_pwm_sequencer: STEP_CYCLES must be >= 2");
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic [1:0]          mode_q;
  logic                mode_chg;
  logic                tick;
  logic                wrap;

  logic [PWM_BITS-1:0] shadow [NUM_CH];
  logic [PWM_BITS-1:0] active [NUM_CH];

  logic [STEP_W-1:0]   step_idx;
  logic [STEP_W-1:0]   step_idx_nxt;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  logic [0:0]          dir;
  logic [0:0]          dir_nxt;

  logic [PROD_W-1:0]   brt_prod [NUM_CH];
  logic [PWM_BITS-1:0] eff      [NUM_CH];
  logic [PWM_BITS-1:0] cmp_cnt;
  logic [PWM_BITS-1:0] cmp_eff  [NUM_CH];
  logic [NUM_CH-1:0]   pwm_q;

  assign wrap     = (pwm_cnt == CNT_MAX);
  assign mode_chg = (bus.mode != mode_q);
  // A mode change swallows a coincident tick.
  assign tick     = bus.en && (prescaler == PRE_LAST) && !mode_chg;

  // PWM counter, step prescaler and previous-mode register
  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt   <= '0;
      prescaler <= '0;
      mode_q    <= MODE_STATIC;
    end else begin
      mode_q <= bus.mode;
      if (!bus.en) begin
        pwm_cnt   <= '0;
        prescaler <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        if (mode_chg || (prescaler == PRE_LAST)) begin
          prescaler <= '0;
        end else begin
          prescaler <= prescaler + PRE_W'(1);
        end
      end
    end
  end

  // Shadow captures on load; active only changes at the period wrap so no period mixes duties
  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (bus.load) begin
          shadow[i] <= bus.duty_in[i*PWM_BITS +: PWM_BITS];
        end
        if (wrap) begin
          active[i] <= bus.load ? bus.duty_in[i*PWM_BITS +: PWM_BITS] : shadow[i];
        end
      end
    end
  end

  // Sequencer state register: rotate slot, breathe level and fade direction
  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      step_idx <= '0;
      level    <= '0;
      dir      <= DIR_UP;
    end else begin
      step_idx <= step_idx_nxt;
      level    <= level_nxt;
      dir      <= dir_nxt;
    end
  end

  // Sequencer next state; level saturates at both ends instead of wrapping
  always_comb begin
    step_idx_nxt = step_idx;
    level_nxt    = level;
    dir_nxt      = dir;
    if (mode_chg) begin
      step_idx_nxt = '0;
      level_nxt    = '0;
      dir_nxt      = DIR_UP;
    end else if (tick) begin
      case (bus.mode)
        MODE_ROTATE: begin
          step_idx_nxt = (step_idx == SLOT_OFF) ? '0 : step_idx + STEP_W'(1);
        end
        MODE_BREATHE: begin
          if (dir == DIR_UP) begin
            if (level != CNT_MAX) level_nxt = level + PWM_BITS'(1);
            if (level >= CNT_MAX - PWM_BITS'(1)) dir_nxt = DIR_DOWN;
          end else begin
            if (level != '0) level_nxt = level - PWM_BITS'(1);
            if (level <= PWM_BITS'(1)) dir_nxt = DIR_UP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Effective per-channel duty for the current mode; reserved mode behaves as STATIC
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      brt_prod[i] = PROD_W'(active[i]) * PROD_W'(level);
      case (bus.mode)
        MODE_ROTATE:  eff[i] = (step_idx == STEP_W'(i)) ? active[i] : '0;
        MODE_BREATHE: eff[i] = PWM_BITS'(brt_prod[i] >> PWM_BITS);
        default:      eff[i] = active[i];
      endcase
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  logic [PWM_BITS-1:0] cnt_d;
  logic [PWM_BITS-1:0] eff_g [NUM_CH];

  // Squaring curve stage; pwm_cnt is delayed alongside so the compare stays aligned
  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      cnt_d <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        eff_g[i] <= '0;
      end
    end else begin
      cnt_d <= pwm_cnt;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        eff_g[i] <= PWM_BITS'((PROD_W'(eff[i]) * PROD_W'(eff[i])) >> PWM_BITS);
      end
    end
  end

  always_comb begin
    cmp_cnt = cnt_d;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cmp_eff[i] = eff_g[i];
    end
  end
`else
  always_comb begin
    cmp_cnt = pwm_cnt;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cmp_eff[i] = eff[i];
    end
  end
`endif

  // Registered comparators; en low clears outputs on the next edge
  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        pwm_q[i] <= bus.en && (cmp_cnt < cmp_eff[i]);
      end
    end
  end

  assign bus.pwm_out  = pwm_q;
  assign bus.step_idx = step_idx;
  assign bus.level    = level;

endmodule
